// File: rtl/simon_sequencer.sv
// Simon Says game controller: latches a 32-bit seed as 16 two-bit colours,
// plays a growing prefix on the LEDs each round and checks the player's presses.
module simon_sequencer #(
  parameter int SHOW_TICKS    = 25_000_000,
  parameter int GAP_TICKS     = 12_500_000,
  parameter int TIMEOUT_TICKS = 250_000_000,
  parameter int MAX_LEN       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [3:0]  btn,
  output logic [3:0]  led,
  output logic [4:0]  level,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam int MAX_AB    = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int MAX_TICKS = (MAX_AB > TIMEOUT_TICKS) ? MAX_AB : TIMEOUT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SHOW,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    pattern_q, pattern_d;
  logic [3:0]     idx_q, idx_d;
  logic [4:0]     level_q, level_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     led_q, led_d;
  logic           busy_q, win_q, lose_q;

  logic [1:0]     cur_colour;
  logic [3:0]     cur_onehot;
  logic           idx_last;

  assign cur_colour = pattern_q[{idx_q, 1'b0} +: 2];
  assign cur_onehot = 4'b0001 << cur_colour;
  assign idx_last   = (({1'b0, idx_q} + 5'd1) == level_q);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    idx_d     = idx_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          pattern_d = seed;
          level_d   = 5'd1;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_TICKS - 1)) begin
          cnt_d   = '0;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (cnt_q == CW'(SHOW_TICKS - 1)) begin
          cnt_d = '0;
          if (idx_last) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INPUT: begin
        // The timeout counter only advances on idle cycles and restarts per press.
        if (btn == 4'b0000) begin
          if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = S_LOSE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (btn == cur_onehot) begin
          cnt_d = '0;
          if (idx_last) begin
            if (level_q == MAX_LEN_L) begin
              state_d = S_WIN;
            end else begin
              level_d = level_q + 5'd1;
              idx_d   = '0;
              state_d = S_GAP;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d   = '0;
          state_d = S_LOSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LED value for the upcoming state, so the display comes straight from a flop.
  always_comb begin
    led_d = 4'b0000;
    case (state_d)
      S_SHOW:  led_d = 4'b0001 << pattern_d[{idx_d, 1'b0} +: 2];
      S_WIN:   led_d = 4'b1111;
      default: led_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      idx_q     <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      idx_q     <= idx_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      busy_q    <= (state_d == S_GAP) || (state_d == S_SHOW) || (state_d == S_INPUT);
      win_q     <= (state_d == S_WIN);
      lose_q    <= (state_d == S_LOSE);
    end
  end

  assign led   = (state_q == S_INPUT) ? btn : led_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Randomised game-level bench for simon_sequencer: a procedural game model
// predicts every cycle of playback, input, timeout and end-of-game display.
module tb_simon_sequencer;

  localparam int SHOW = 3;
  localparam int GAP  = 2;
  localparam int TMO  = 20;
  localparam int MAXL = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed  = '0;
  logic [3:0]  btn   = '0;
  logic [3:0]  led;
  logic [4:0]  level;
  logic        busy, win, lose;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pat;
  int          m_level;
  int          m_idle;
  int          m_outcome;  // 0 playing, 1 won, 2 lost

  simon_sequencer #(
    .SHOW_TICKS   (SHOW),
    .GAP_TICKS    (GAP),
    .TIMEOUT_TICKS(TMO),
    .MAX_LEN      (MAXL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .seed (seed),
    .btn  (btn),
    .led  (led),
    .level(level),
    .busy (busy),
    .win  (win),
    .lose (lose)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400us");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    start = 1'b0;
    btn   = 4'b0000;
  endtask

  function automatic logic [3:0] colour(input logic [31:0] p, input int i);
    logic [1:0] c;
    c = p[2*i +: 2];
    return 4'b0001 << c;
  endfunction

  task automatic expect_outs(input string tag, input logic [3:0] e_led, input int e_level,
                             input logic e_busy, input logic e_win, input logic e_lose);
    check_eq({tag, ".led"},   led,   e_led);
    check_eq({tag, ".level"}, level, e_level);
    check_eq({tag, ".busy"},  busy,  e_busy);
    check_eq({tag, ".win"},   win,   e_win);
    check_eq({tag, ".lose"},  lose,  e_lose);
  endtask

  task automatic start_game(input logic [31:0] s);
    seed  = s;
    start = 1'b1;
    cyc();
    seed    = $urandom();  // must not matter once latched
    m_pat   = s;
    m_level = 1;
    m_outcome = 0;
  endtask

  task automatic playback(input bit noise);
    for (int i = 0; i < m_level; i++) begin
      for (int g = 0; g < GAP; g++) begin
        expect_outs("gap", 4'b0000, m_level, 1'b1, 1'b0, 1'b0);
        if (noise) begin
          btn   = 4'($urandom_range(0, 15));
          start = 1'($urandom_range(0, 1));
        end
        cyc();
      end
      for (int t = 0; t < SHOW; t++) begin
        expect_outs("show", colour(m_pat, i), m_level, 1'b1, 1'b0, 1'b0);
        if (noise) begin
          btn   = 4'($urandom_range(0, 15));
          start = 1'($urandom_range(0, 1));
        end
        cyc();
      end
    end
  endtask

  task automatic idle_cycle(input bit noise);
    check_eq("input.busy", busy, 1'b1);
    check_eq("input.lose", lose, 1'b0);
    btn = 4'b0000;
    if (noise) start = 1'($urandom_range(0, 1));
    #1;
    check_eq("input.led_dark", led, 4'b0000);
    cyc();
    m_idle++;
    if (m_idle >= TMO) m_outcome = 2;
  endtask

  task automatic press(input logic [3:0] b);
    check_eq("press.busy",  busy,  1'b1);
    check_eq("press.level", level, m_level);
    btn = b;
    #1;
    check_eq("press.led_mirror", led, b);
    cyc();
  endtask

  task automatic play_game(input int gnum, input logic [31:0] s, input int fail_round,
                           input int fail_idx, input int fail_kind,
                           input logic [3:0] bad_in, input bit noise);
    int         round_len;
    logic [3:0] exp_b;
    logic [3:0] b;
    bit         hit;
    start_game(s);
    while (m_outcome == 0) begin
      playback(noise);
      m_idle    = 0;
      round_len = m_level;
      for (int i = 0; i < round_len && m_outcome == 0; i++) begin
        exp_b = colour(m_pat, i);
        hit   = (m_level == fail_round) && (i == fail_idx);
        if (noise) repeat ($urandom_range(0, 4)) idle_cycle(noise);
        if (hit && fail_kind == 2) begin
          for (int k = 0; k < TMO + 5 && m_outcome == 0; k++) idle_cycle(noise);
        end else begin
          b = exp_b;
          if (hit && fail_kind == 1) begin
            b = bad_in;
            while (b == exp_b || b == 4'b0000) b = 4'($urandom_range(1, 15));
          end
          press(b);
          if (b != exp_b) begin
            m_outcome = 2;
          end else begin
            m_idle = 0;
            if (i == round_len - 1) begin
              if (m_level == MAXL) m_outcome = 1;
              else m_level++;
            end
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      expect_outs("end", (m_outcome == 1) ? 4'b1111 : 4'b0000, m_level, 1'b0,
                  m_outcome == 1, m_outcome == 2);
      btn = 4'($urandom_range(0, 15));
      cyc();
    end
    $display("game %0d seed=%08h outcome=%s level=%0d", gnum, s,
             (m_outcome == 1) ? "win" : "lose", m_level);
  endtask

  initial begin
    int fr;
    reset = 1'b0;
    repeat (3) cyc();
    expect_outs("reset_held", 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    expect_outs("reset_release", 4'b0000, 0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of SHOW, with start asserted alongside
    start_game(32'h0000_00E4);
    repeat (GAP) cyc();
    expect_outs("pre_reset_show", 4'b0001, 1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b1;
    cyc();
    reset = 1'b1;
    expect_outs("reset_mid_show", 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      btn = 4'($urandom_range(0, 15));
      cyc();
      expect_outs("idle_after_reset", 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    end

    // directed games: full win, wrong press, multi-hot, timeout, restart
    play_game(0, 32'h0000_00E4, 0, 0, 0, 4'b0000, 1'b0);
    play_game(1, 32'h0000_00E4, 1, 0, 1, 4'b0010, 1'b0);
    play_game(2, 32'h0000_00E4, 1, 0, 1, 4'b0011, 1'b0);
    play_game(3, 32'h0000_00E4, 1, 0, 2, 4'b0000, 1'b1);
    play_game(4, 32'hFFFF_FFFF, 0, 0, 0, 4'b0000, 1'b1);
    play_game(5, 32'h0000_00E4, 3, 2, 1, 4'b1100, 1'b1);

    for (int g = 6; g < 40; g++) begin
      fr = $urandom_range(1, MAXL);
      play_game(g, $urandom(), fr, $urandom_range(0, fr - 1), $urandom_range(0, 2),
                4'b0000, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game controller for Simon Says. It latches the 32-bit seed from the seed generator and treats it as a sequence of 16 two-bit colours. Each round it plays the first `level` colours on the LEDs, then checks the player's button presses against them. It grows the sequence one colour per round until the player either wins or loses.

## Interface

**Parameters**
- `SHOW_TICKS`, default 25_000_000: cycles each colour's LED stays lit during playback.
- `GAP_TICKS`, default 12_500_000: cycles all LEDs stay dark between colours, and also before the first colour of a round.
- `TIMEOUT_TICKS`, default 250_000_000: cycles allowed between presses in the input phase before a loss.
- `MAX_LEN`, default 16: sequence length needed to win; legal range is 1..16.

**Ports** (name, direction, width, meaning)
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle pulse that begins a new game.
- `seed` in 32: pattern source; colour i is `seed[2i+1:2i]`.
- `btn` in 4: button press pulses, already debounced and edge-detected upstream.
- `led` out 4: one-hot colour display.
- `level` out 5: current sequence length, 0..16.
- `busy` out 1: high while playing back or waiting for input.
- `win` out 1: high while in the WIN state.
- `lose` out 1: high while in the LOSE state.

## Operation

**Colour mapping:** 2'b00→led 4'b0001, 2'b01→4'b0010, 2'b10→4'b0100, 2'b11→4'b1000.

**States:** IDLE, GAP, SHOW, INPUT, WIN, LOSE.

- **Reset** (reset==0 at a rising edge):
  - State goes to IDLE.
  - `led`=0, `level`=0, `busy`=0, `win`=0, `lose`=0.
  - Internal registers clear: `pattern`=0, `idx`=0, `cnt`=0.
  - Reset overrides all other inputs, including reset in the middle of playback or input.
- **IDLE:**
  - A `start` pulse latches `pattern`<=`seed`, sets `level`<=1 and `idx`<=0, then goes to GAP.
- **GAP:**
  - `led`=0.
  - After GAP_TICKS cycles, goes to SHOW.
- **SHOW:**
  - `led` = mapped colour at `pattern[idx]`, held for SHOW_TICKS cycles.
  - Then `idx`++. If `idx` now equals `level`, set `idx`<=0 and go to INPUT; otherwise go to GAP.
- **INPUT:**
  - `led` mirrors `btn`, combinationally, for player feedback.
  - A cycle with `btn`==0 increments the timeout counter.
  - **Correct press:** `btn` is exactly one-hot and equals the expected colour. Clear the timeout counter and increment `idx`.
    - If `idx`+1==`level` and `level`==MAX_LEN: go to WIN.
    - If `idx`+1==`level` and `level`<MAX_LEN: `level`++, `idx`<=0, go to GAP.
  - **Wrong press:** any non-zero `btn` that is not the correct one-hot value, including multi-hot values, goes to LOSE.
  - **Timeout:** the counter reaching TIMEOUT_TICKS goes to LOSE.
- **WIN / LOSE:**
  - `led`=4'b1111 for WIN, 4'b0000 for LOSE.
  - `level` holds its final value.
  - `start` re-latches `seed` and restarts exactly as from IDLE.
- **Ignored inputs:**
  - `btn` is ignored in IDLE, GAP, SHOW, WIN and LOSE.
  - `start` is ignored in GAP, SHOW and INPUT; no restart is allowed mid-game.
- **Arithmetic:**
  - `idx` is 4 bits; `level` is 5 bits.
  - Phase counters are sized to the maximum of the three tick parameters, count from 0 and never wrap.
  - `seed` changes after the latch have no effect.

## Timing

- `start` sampled at edge N: `busy`=1 from N+1; `led` is dark for cycles N+1..N+GAP_TICKS; the first colour is lit from N+GAP_TICKS+1.
- Each colour occupies GAP_TICKS+SHOW_TICKS cycles, so a round's playback lasts `level`×(GAP_TICKS+SHOW_TICKS) cycles.
- A press sampled at edge M:
  - `win` or `lose` is high from M+1.
  - The next round's GAP begins at M+1.
- `busy` drops in the same cycle that `win` or `lose` rises.
- All outputs are registered except `led` in INPUT.

## Test plan

Run with SHOW_TICKS=3, GAP_TICKS=2, TIMEOUT_TICKS=20 and MAX_LEN=4.

1. **Reset:** assert reset mid-SHOW → next cycle `led`=0, `level`=0, `busy`=`win`=`lose`=0, and the state is IDLE.
2. **Playback:** seed=32'h0000_00E4, then `start` → `led` is 0 for 2 cycles, then 4'b0001 for 3 cycles, then state is INPUT with `level`=1.
3. **Full win:** seed=32'h0000_00E4; answer each round correctly with btn=0001, 0010, 0100, 1000 in order → round 2 plays 0001, 0010; `win`=1 and `led`=4'b1111 after the 4th press of round 4; `level`=4.
4. **Wrong and multi-hot press:** seed=32'h0000_00E4.
   - Round 1, press 4'b0010 → `lose`=1 next cycle, `level`=1.
   - Restart, then press 4'b0011 → `lose`=1.
5. **Timeout and ignored input:** pulse btn=4'b0001 during SHOW → no state effect. Then hold btn=0 in INPUT for 20 cycles → `lose`=1.
6. **Restart:** from LOSE, set seed=32'hFFFF_FFFF and pulse `start` → `level`=1 and the first colour shown is 4'b1000; a `start` during SHOW is ignored.
